// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel frame path: pixel width, sequencer states, 3x3 tap indices.
// Tap indices are in raster order within the window; P4 is the centre.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row pixel store, single port, read-before-write: rd_dat is the old word at addr, combinational.
// No backpressure; the caller qualifies writes with we.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_dat,
  output logic [PIX_W-1:0] rd_dat
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_dat;
  end

endmodule

// File: rtl/sobel_module.sv
// Sobel edge decision: |Gx| + |Gy| over the eight border taps, compared against threshold.
// Purely combinational, no handshake.
module sobel_module
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0] p0,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [7:0]       threshold,
  output logic             result
);

  logic [10:0]        gxp, gxn, gyp, gyn;
  logic signed [11:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;

  always_comb begin
    gxp    = {3'd0, p2} + {2'd0, p5, 1'b0} + {3'd0, p8};
    gxn    = {3'd0, p0} + {2'd0, p3, 1'b0} + {3'd0, p6};
    gyp    = {3'd0, p6} + {2'd0, p7, 1'b0} + {3'd0, p8};
    gyn    = {3'd0, p0} + {2'd0, p1, 1'b0} + {3'd0, p2};
    gx     = $signed({1'b0, gxp}) - $signed({1'b0, gxn});
    gy     = $signed({1'b0, gyp}) - $signed({1'b0, gyn});
    ax     = gx[11] ? 11'(-gx) : gx[10:0];
    ay     = gy[11] ? 11'(-gy) : gy[10:0];
    mag    = {1'b0, ax} + {1'b0, ay};
    result = mag > {4'd0, threshold};
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: rows buffered in two line buffers, one registered edge bit per interior pixel, 1-cycle latency.
// Input stalls whenever the output register is full and not drained; optional edge_count under SOBEL_STATS_EN.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       threshold,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             edge_out,
  output logic             edge_valid,
  input  logic             edge_ready,
  output logic             busy,
  output logic             done
`ifdef SOBEL_STATS_EN
  ,
  output logic [31:0]      edge_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [7:0]       thr;
  logic             accept, start_acc, last_pix, emit, result;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] w0, w1, w3, w4, w6, w7;
  logic [PIX_W-1:0] tap [9];

  assign accept    = pix_valid && pix_ready;
  assign start_acc = start && (state == IDLE);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign emit      = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (accept && last_pix) state_nxt = FLUSH;
      FLUSH:   if (!edge_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state == STREAM) && (!edge_valid || edge_ready);
    busy      = (state != IDLE);
    done      = (state == FLUSH) && !edge_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      thr <= '0;
    end else if (start_acc) begin
      col <= '0;
      row <= '0;
      thr <= threshold;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(col), .wr_dat(pix_in), .rd_dat(lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(col), .wr_dat(lb0_rd), .rd_dat(lb1_rd)
  );

  // Registered window columns; they carry across row wraps, but emit waits for two same-row shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {w0, w1, w3, w4, w6, w7} <= '0;
    end else if (accept) begin
      w0 <= w1;  w1 <= lb1_rd;
      w3 <= w4;  w4 <= lb0_rd;
      w6 <= w7;  w7 <= pix_in;
    end
  end

  always_comb begin
    tap[P0] = w0;  tap[P1] = w1;  tap[P2] = lb1_rd;
    tap[P3] = w3;  tap[P4] = w4;  tap[P5] = lb0_rd;
    tap[P6] = w6;  tap[P7] = w7;  tap[P8] = pix_in;
  end

  sobel_module u_sobel (
    .p0(tap[P0]), .p1(tap[P1]), .p2(tap[P2]), .p3(tap[P3]),
    .p5(tap[P5]), .p6(tap[P6]), .p7(tap[P7]), .p8(tap[P8]),
    .threshold(thr), .result(result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_out   <= 1'b0;
      edge_valid <= 1'b0;
    end else if (emit) begin
      edge_out   <= result;
      edge_valid <= 1'b1;
    end else if (edge_ready) begin
      edge_valid <= 1'b0;
    end
  end

`ifdef SOBEL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      edge_count <= '0;
    else if (start_acc)
      edge_count <= '0;
    else if (edge_valid && edge_ready && edge_out && (edge_count != '1))
      edge_count <= edge_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 frame, threshold 200.
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid, edge_ready;
  logic       pix_ready, edge_out, edge_valid, busy, done;
  logic [7:0] threshold, pix_in;
`ifdef SOBEL_STATS_EN
  logic [31:0] edge_count;
`endif

  int tests = 0;
  int failed = 0;
  int done_total = 0;
  logic [7:0] frame [16];
  int n_out, n_done;
  logic [7:0] outs;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_total <= done_total + 1;

  sobel_frame_ctrl #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .edge_out(edge_out), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .busy(busy), .done(done)
`ifdef SOBEL_STATS_EN
    , .edge_count(edge_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] left, input logic [7:0] right);
    for (int i = 0; i < 16; i++) frame[i] = ((i % 4) < 2) ? left : right;
  endtask

  task automatic do_start(input logic [7:0] thr);
    @(negedge clk);
    start = 1'b1;
    threshold = thr;
    @(negedge clk);
    start = 1'b0;
    threshold = 8'd0;
    #1 check("busy_after_start", busy, 1);
  endtask

  // Streams the whole frame; threshold input is driven to 0 throughout so a non-held threshold shows up.
  task automatic run_frame(input int bp_len, input bit mid_start);
    int idx = 0;
    int cyc = 0;
    int bp_left = 0;
    int hs_cyc = -10;
    bit bp_started = 1'b0;
    logic hold = 1'b0;
    n_out = 0;
    n_done = 0;
    outs = '0;
    while (cyc < 200 && n_done == 0) begin
      @(negedge clk);
      cyc++;
      start = mid_start && (cyc == 3);
      threshold = 8'd0;
      if (bp_len > 0 && !bp_started && edge_valid === 1'b1) begin
        bp_started = 1'b1;
        bp_left = bp_len;
        hold = edge_out;
      end
      edge_ready = (bp_left == 0);
      pix_valid = (idx < 16);
      if (idx < 16) pix_in = frame[idx];
      else          pix_in = 8'h00;
      #1;
      if (bp_left > 0) begin
        check("bp_pix_ready", pix_ready, 0);
        check("bp_edge_out_held", edge_out, hold);
        check("bp_edge_valid", edge_valid, 1);
        bp_left--;
      end
      if (mid_start && cyc == 3) check("busy_at_mid_start", busy, 1);
      if (pix_valid && pix_ready) idx++;
      if (edge_valid && edge_ready) begin
        if (n_out < 8) outs[n_out] = edge_out;
        n_out++;
        hs_cyc = cyc;
      end
      if (done === 1'b1) begin
        n_done++;
        check("done_after_last_handshake", cyc, hs_cyc + 1);
      end
    end
    check("frame_done_seen", n_done, 1);
    start = 1'b0;
    pix_valid = 1'b0;
    edge_ready = 1'b1;
    @(negedge clk);
    #1;
    check("done_single_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int acc, c, dt;
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b1;
    edge_ready = 1'b1;
    threshold = 8'd200;
    pix_in = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge_out", edge_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef SOBEL_STATS_EN
    check("rst_edge_count", edge_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_pix_ready", pix_ready, 0);
    check("idle_busy", busy, 0);
    pix_valid = 1'b0;

    // Flat frame
    build_frame(8'h80, 8'h80);
    do_start(8'd200);
    run_frame(0, 1'b0);
    check("flat_count", n_out, 4);
    check("flat_bits", outs, 8'h00);

    // Vertical step
    build_frame(8'h00, 8'hFF);
    do_start(8'd200);
    run_frame(0, 1'b0);
    check("vstep_count", n_out, 4);
    check("vstep_bits", outs, 8'h0F);
`ifdef SOBEL_STATS_EN
    check("vstep_edge_count", edge_count, 4);
    repeat (3) @(negedge clk);
    #1 check("edge_count_hold", edge_count, 4);
`endif

    // Vertical step under backpressure
    do_start(8'd200);
    run_frame(5, 1'b0);
    check("bp_count", n_out, 4);
    check("bp_bits", outs, 8'h0F);
`ifdef SOBEL_STATS_EN
    check("bp_edge_count", edge_count, 4);
`endif

    // Reset after 6 accepted pixels
    build_frame(8'h80, 8'h80);
    do_start(8'd200);
    acc = 0;
    c = 0;
    while (acc < 6 && c < 50) begin
      @(negedge clk);
      c++;
      pix_valid = 1'b1;
      pix_in = frame[acc];
      edge_ready = 1'b1;
      #1;
      if (pix_ready) acc++;
    end
    check("midrst_fed", acc, 6);
    @(negedge clk);
    pix_valid = 1'b0;
    dt = done_total;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_edge_valid", edge_valid, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("midrst_no_done", done_total, dt);
    do_start(8'd200);
    run_frame(0, 1'b0);
    check("midrst_frame_count", n_out, 4);
    check("midrst_frame_bits", outs, 8'h00);

    // Weak step (|G| = 64) with a start pulse carrying threshold 0 mid-frame
    build_frame(8'h00, 8'h10);
    do_start(8'd200);
    run_frame(0, 1'b1);
    check("busy_start_count", n_out, 4);
    check("busy_start_bits", outs, 8'h00);
`ifdef SOBEL_STATS_EN
    check("weak_edge_count", edge_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the `sobel_module` edge datapath. It accepts a raster pixel stream over a valid/ready handshake and buffers two previous rows. It assembles the 3x3 neighbourhood around each interior pixel, drives the eight `sobel_module` taps plus the threshold, and emits one registered edge bit per interior pixel over a valid/ready output. It sits between the camera/frame-store reader and the edge-map writer.

## Interface
- `IMG_W`, 64, pixels per row (>= 3)
- `IMG_H`, 48, rows per frame (>= 3)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle frame start pulse; ignored while `busy`
- `threshold`  in  8  edge threshold; sampled on accepted `start`, held for the frame
- `pix_in`  in  8  input pixel, raster order
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  controller accepts `pix_in`
- `edge_out`  out  1  edge decision for the current interior centre
- `edge_valid`  out  1  `edge_out` valid
- `edge_ready`  in  1  downstream accepts `edge_out`
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at end of frame
- `edge_count`  out  32  edge count (only with `SOBEL_STATS_EN`)

## Operation
- FSM: IDLE -> STREAM on `start`; STREAM -> FLUSH once pixel (IMG_H-1, IMG_W-1) is accepted; FLUSH -> IDLE once the output register is empty, pulsing `done` on that transition.
- Accept: `pix_ready = (state==STREAM) && (!edge_valid || edge_ready)`. Transfer when `pix_valid && pix_ready`.
- Column counter `col` and row counter `row` advance per accepted pixel. `col` wraps at IMG_W-1, then `row` increments. Both clear on `start`.
- Two line buffers, IMG_W x 8 each, are addressed by `col`. Per accept: lb0[col] <= pix_in; lb1[col] <= old lb0[col].
- Window: 3 rows x 2 registered columns, plus a combinational newest column (lb1[col], lb0[col], pix_in). Registered columns shift left on each accept.
- Tap mapping: p0,p1 = top row registers; p2 = lb1[col]. p3 = middle-left register; p5 = lb0[col]. p6,p7 = bottom row registers; p8 = pix_in. The centre tap p4 is unused by `sobel_module`.
- Output: on an accept with row >= 2 and col >= 2, `edge_out <= result` and `edge_valid <= 1`. Otherwise `edge_valid` clears on `edge_ready`.
- Each frame produces exactly (IMG_H-2)*(IMG_W-2) outputs. Border pixels produce nothing.
- Stale line-buffer contents are never used for output, so the buffers are not cleared between frames.

## Timing
- Reset values: state IDLE; all counters 0; `pix_ready`, `edge_out`, `edge_valid`, `busy`, `done` 0; `edge_count` 0.
- Latency: `edge_valid` rises the cycle after the qualifying pixel is accepted.
- Throughput: one pixel per cycle while `edge_ready` is high.
- `busy` is high from the cycle after `start` through FLUSH. `done` is high for one cycle as `busy` falls.
- Backpressure: while `edge_valid && !edge_ready`, `edge_out` is held stable and `pix_ready` is 0. Nothing is dropped.
- If `start` coincides with `busy`, it has no effect.
- `rst` mid-frame returns the block to IDLE immediately. Any pending output is discarded and `done` is not pulsed.

## Configuration
- `SOBEL_STATS_EN` defined: a 32-bit `edge_count` increments on each output handshake with `edge_out==1`. It clears on accepted `start`, saturates at all-ones, and holds after `done`.
- Without the macro, the port and the counter are absent.

## Structure
- A shared `sobel_pkg` holds: the 8-bit pixel width constant, the FSM state enum (IDLE, STREAM, FLUSH), and the tap index constants P0..P8.
- Sub-module `sobel_line_buffer`: single-port, read-before-write IMG_W x 8 RAM, instantiated twice.
- `sobel_module` is instantiated unchanged.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, threshold=200.
- Reset check: assert `rst` -> every output is 0, state IDLE, and `pix_valid=1` is not accepted.
- Flat frame: 16 pixels of 0x80 with `edge_ready=1` -> 4 outputs, all 0. `done` pulses one cycle after the 4th output handshake.
- Vertical step: columns 0-1 = 0x00, columns 2-3 = 0xFF -> 4 outputs, all 1. `edge_count=4` under `SOBEL_STATS_EN`.
- Backpressure: during the vertical-step frame, hold `edge_ready=0` for 5 cycles after the first `edge_valid` -> `edge_out` stable, `pix_ready=0`, still 4 ones delivered in order.
- Reset mid-frame: assert `rst` after 6 accepted pixels, release, start a flat 0x80 frame -> exactly 4 zeros and one `done`.
- Start while busy: pulse `start` with threshold=0 during STREAM -> ignored, and the frame still uses threshold 200.
